// File: rtl/decode_pkg.sv
// Shared decode-side types: fetch buffer entry layout.
// Imported by the fetch buffer and by the decoder.
package decode_pkg;

  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               xcpt_pf_if;
    logic               xcpt_ae_if;
    logic               bp_debug_if;
    logic               bp_xcpt_if;
    logic               is_sfb;
  } fb_entry_t;

endpackage

// File: rtl/decode_fetch_buffer.sv
// Circular fetch buffer in front of decode: accepts packets of up to two
// instructions with per-slot flags and presents one head entry per cycle.
// Ports:
//   clk, rst, flush        - clock, async active-high reset, redirect flush
//   enq_*                  - fetch packet in (mask, 2 instrs, per-slot flags)
//   deq_*                  - head entry out to decoder (valid/ready)
//   count                  - current occupancy, 0..DEPTH
module decode_fetch_buffer
  import decode_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               enq_valid,
  output logic               enq_ready,
  input  logic [1:0]         enq_mask,
  input  logic [INSTR_W-1:0] enq_instr0,
  input  logic [INSTR_W-1:0] enq_instr1,
  input  logic [1:0]         enq_xcpt_pf_if,
  input  logic [1:0]         enq_xcpt_ae_if,
  input  logic [1:0]         enq_bp_debug_if,
  input  logic [1:0]         enq_bp_xcpt_if,
  input  logic [1:0]         enq_is_sfb,
  output logic               deq_valid,
  input  logic               deq_ready,
  output logic [INSTR_W-1:0] deq_instr,
  output logic               deq_xcpt_pf_if,
  output logic               deq_xcpt_ae_if,
  output logic               deq_bp_debug_if,
  output logic               deq_bp_xcpt_if,
  output logic               deq_is_sfb,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  fb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   tail_p1;

  fb_entry_t          e0;
  fb_entry_t          e1;
  fb_entry_t          first;
  logic               has0;
  logic               has1;
  logic               enq_fire;
  logic               deq_fire;
  logic [1:0]         n_enq;
  fb_entry_t          head_e;

  assign enq_ready = count <= CNT_W'(DEPTH - 2);
  assign deq_valid = count != '0;

  assign enq_fire = enq_valid && enq_ready && !flush;
  assign deq_fire = deq_valid && deq_ready && !flush;

  assign e0 = '{
    instr:       enq_instr0,
    xcpt_pf_if:  enq_xcpt_pf_if[0],
    xcpt_ae_if:  enq_xcpt_ae_if[0],
    bp_debug_if: enq_bp_debug_if[0],
    bp_xcpt_if:  enq_bp_xcpt_if[0],
    is_sfb:      enq_is_sfb[0]
  };

  assign e1 = '{
    instr:       enq_instr1,
    xcpt_pf_if:  enq_xcpt_pf_if[1],
    xcpt_ae_if:  enq_xcpt_ae_if[1],
    bp_debug_if: enq_bp_debug_if[1],
    bp_xcpt_if:  enq_bp_xcpt_if[1],
    is_sfb:      enq_is_sfb[1]
  };

  // A faulting slot 0 ends the packet: slot 1 was fetched past the fault.
  assign has0 = enq_mask[0];
  assign has1 = enq_mask[1] &&
                !(enq_mask[0] && (enq_xcpt_pf_if[0] || enq_xcpt_ae_if[0]));

  // Compaction: the first surviving slot always lands at tail.
  assign first   = has0 ? e0 : e1;
  assign n_enq   = enq_fire ? ({1'b0, has0} + {1'b0, has1}) : 2'd0;
  assign tail_p1 = tail + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (n_enq != 2'd0) mem[tail] <= first;
    if (n_enq == 2'd2) mem[tail_p1] <= e1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PTR_W'(n_enq);
      if (deq_fire) head <= head + PTR_W'(1);
      count <= count + CNT_W'(n_enq) - CNT_W'(deq_fire);
    end
  end

  always_comb begin
    head_e = mem[head];
    if (!deq_valid) head_e = '0;
  end

  assign deq_instr       = head_e.instr;
  assign deq_xcpt_pf_if  = head_e.xcpt_pf_if;
  assign deq_xcpt_ae_if  = head_e.xcpt_ae_if;
  assign deq_bp_debug_if = head_e.bp_debug_if;
  assign deq_bp_xcpt_if  = head_e.bp_xcpt_if;
  assign deq_is_sfb      = head_e.is_sfb;

endmodule
